// File: rtl/logic_result_buffer_if.sv
// logic_result_buffer_if
//   Handshake bundle between the 4-bit AND/XOR logic unit, the result buffer
//   and the writeback stage.
//   slave  : buffer side. It receives In_* and Out_Ready/Flush and drives
//            In_Ready, Out_*, and Count.
//   master : environment side. It is the logic unit plus writeback seen as a
//            single driver.
//   Optional macro LOGIC_BUF_PARITY_EN adds the Out_P signal.
interface logic_result_buffer_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
);
  logic                     In_Valid;
  logic                     In_Ready;
  logic [WIDTH-1:0]         In_R;
  logic                     In_Op;
  logic                     Out_Valid;
  logic                     Out_Ready;
  logic [WIDTH-1:0]         Out_R;
  logic                     Out_Op;
  logic                     Out_Z;
  logic                     Out_N;
  logic [$clog2(DEPTH):0]   Count;
  logic                     Flush;
`ifdef LOGIC_BUF_PARITY_EN
  logic                     Out_P;
`endif

  modport slave (
    input  In_Valid, In_R, In_Op, Out_Ready, Flush,
    output In_Ready, Out_Valid, Out_R, Out_Op, Out_Z, Out_N, Count
`ifdef LOGIC_BUF_PARITY_EN
    , output Out_P
`endif
  );

  modport master (
    output In_Valid, In_R, In_Op, Out_Ready, Flush,
    input  In_Ready, Out_Valid, Out_R, Out_Op, Out_Z, Out_N, Count
`ifdef LOGIC_BUF_PARITY_EN
    , input Out_P
`endif
  );
endinterface

// File: rtl/logic_result_buffer.sv
// logic_result_buffer
//   Elastic FIFO that sits after the 4-bit AND/XOR logic unit. It stores up to
//   DEPTH {Op, R} entries in order and presents the oldest entry, together with
//   Zero and Negative flags, to writeback.
// Ports
//   Clk   : rising-edge clock
//   Reset : synchronous, active-high
//   bus   : logic_result_buffer_if.slave, which carries the following signals.
//           In_Valid/In_Ready/In_R/In_Op form the push side.
//           Out_Valid/Out_Ready/Out_R/Out_Op/Out_Z/Out_N form the pop side.
//           Count gives the occupancy and Flush discards all entries.
// Optional macro
//   LOGIC_BUF_PARITY_EN stores ^In_R with each entry and drives bus.Out_P.
module logic_result_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input logic                   Clk,
  input logic                   Reset,
  logic_result_buffer_if.slave  bus
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef LOGIC_BUF_PARITY_EN
  localparam int EW = WIDTH + 2;
`else
  localparam int EW = WIDTH + 1;
`endif

  // The entry layout is {[parity,] op, r}.
  function automatic logic [EW-1:0] pack_entry(input logic [WIDTH-1:0] r, input logic op);
`ifdef LOGIC_BUF_PARITY_EN
    pack_entry = {^r, op, r};
`else
    pack_entry = {op, r};
`endif
  endfunction

  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [EW-1:0] head_q, head_d;
  logic          in_ready;
  logic          out_valid;
  logic          push;
  logic          pop;

  always_comb begin
    // In_Ready looks only at the occupancy. A full buffer refuses a push
    // even when it pops in the same cycle.
    in_ready  = (count_q < CW'(DEPTH)) & ~Reset;
    out_valid = (count_q != '0);
    push      = bus.In_Valid & in_ready & ~bus.Flush;
    pop       = out_valid & bus.Out_Ready & ~bus.Flush;

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (bus.Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = pack_entry(bus.In_R, bus.In_Op);
        wr_ptr_d        = wr_ptr_q + PW'(1);  // DEPTH is a power of two, so the pointer wraps naturally
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // The head register holds the next oldest entry. When the buffer drains,
    // the register keeps its last value so that Out_R stays stable while empty.
    head_d = (count_d != '0) ? mem_d[rd_ptr_d] : head_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // The storage array holds data only. Occupancy decides which entries are live.
  always_ff @(posedge Clk) begin
    mem_q <= mem_d;
  end

  assign bus.In_Ready  = in_ready;
  assign bus.Out_Valid = out_valid;
  assign bus.Out_R     = head_q[WIDTH-1:0];
  assign bus.Out_Op    = head_q[WIDTH];
  assign bus.Out_Z     = out_valid & (head_q[WIDTH-1:0] == '0);
  assign bus.Out_N     = out_valid & head_q[WIDTH-1];
  assign bus.Count     = count_q;
`ifdef LOGIC_BUF_PARITY_EN
  assign bus.Out_P     = out_valid & head_q[WIDTH+1];
`endif

endmodule

// File: tb/tb_logic_result_buffer.sv
// Testbench for logic_result_buffer (WIDTH=4, DEPTH=2).
// The bench drives inputs just after the falling edge and checks outputs 1 time
// unit later, which reflects the state left by the previous rising edge.
module tb_logic_result_buffer;

  logic Clk;
  logic Reset;

  logic_result_buffer_if #(.WIDTH(4), .DEPTH(2)) bus ();

  logic_result_buffer #(.WIDTH(4), .DEPTH(2)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic       rst;
    logic       iv;
    logic [3:0] r;
    logic       op;
    logic       ordy;
    logic       fl;
    logic       e_irdy;
    logic       e_ov;
    logic [3:0] e_r;
    logic       e_op;
    logic       e_z;
    logic       e_n;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t tbl [16];

  task automatic cmp(input string tag, input string fld, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", tag, fld, act, exp);
    end
  endtask

  task automatic chk(input string tag, input logic irdy, input logic ov, input logic [3:0] r,
                     input logic op, input logic z, input logic n, input logic [1:0] cnt);
    cmp(tag, "In_Ready",  8'(bus.In_Ready),  8'(irdy));
    cmp(tag, "Out_Valid", 8'(bus.Out_Valid), 8'(ov));
    cmp(tag, "Out_R",     8'(bus.Out_R),     8'(r));
    cmp(tag, "Out_Op",    8'(bus.Out_Op),    8'(op));
    cmp(tag, "Out_Z",     8'(bus.Out_Z),     8'(z));
    cmp(tag, "Out_N",     8'(bus.Out_N),     8'(n));
    cmp(tag, "Count",     8'(bus.Count),     8'(cnt));
  endtask

  task automatic step(input logic rst, input logic iv, input logic [3:0] r, input logic op,
                      input logic ordy, input logic fl);
    @(negedge Clk);
    Reset         = rst;
    bus.In_Valid  = iv;
    bus.In_R      = r;
    bus.In_Op     = op;
    bus.Out_Ready = ordy;
    bus.Flush     = fl;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    //        rst   iv    r      op    ordy  fl  | irdy  ov    r      op    z     n     cnt
    // Reset held for 2 cycles, then released.
    tbl[0]  = '{1'b1,1'b0,4'h0,1'b0,1'b0,1'b0, 1'b0,1'b0,4'h0,1'b0,1'b0,1'b0,2'd0};
    tbl[1]  = '{1'b0,1'b0,4'h0,1'b0,1'b0,1'b0, 1'b1,1'b0,4'h0,1'b0,1'b0,1'b0,2'd0};
    // Push 1010 and hold it with Out_Ready=0 for 5 cycles, then pop it.
    tbl[2]  = '{1'b0,1'b1,4'hA,1'b0,1'b0,1'b0, 1'b1,1'b0,4'h0,1'b0,1'b0,1'b0,2'd0};
    tbl[3]  = '{1'b0,1'b0,4'h0,1'b0,1'b0,1'b0, 1'b1,1'b1,4'hA,1'b0,1'b0,1'b1,2'd1};
    tbl[4]  = '{1'b0,1'b0,4'h0,1'b0,1'b0,1'b0, 1'b1,1'b1,4'hA,1'b0,1'b0,1'b1,2'd1};
    tbl[5]  = '{1'b0,1'b0,4'h0,1'b0,1'b0,1'b0, 1'b1,1'b1,4'hA,1'b0,1'b0,1'b1,2'd1};
    tbl[6]  = '{1'b0,1'b0,4'h0,1'b0,1'b0,1'b0, 1'b1,1'b1,4'hA,1'b0,1'b0,1'b1,2'd1};
    tbl[7]  = '{1'b0,1'b0,4'h0,1'b0,1'b0,1'b0, 1'b1,1'b1,4'hA,1'b0,1'b0,1'b1,2'd1};
    tbl[8]  = '{1'b0,1'b0,4'h0,1'b0,1'b1,1'b0, 1'b1,1'b1,4'hA,1'b0,1'b0,1'b1,2'd1};
    // Empty buffer: Out_R holds its last value and the flags are forced to 0.
    tbl[9]  = '{1'b0,1'b0,4'h0,1'b0,1'b1,1'b0, 1'b1,1'b0,4'hA,1'b0,1'b0,1'b0,2'd0};
    // Fill the buffer with 0000/op1 and 0110/op0. Pushes of 1111 are refused,
    // including one in a popping cycle.
    tbl[10] = '{1'b0,1'b1,4'h0,1'b1,1'b0,1'b0, 1'b1,1'b0,4'hA,1'b0,1'b0,1'b0,2'd0};
    tbl[11] = '{1'b0,1'b1,4'h6,1'b0,1'b0,1'b0, 1'b1,1'b1,4'h0,1'b1,1'b1,1'b0,2'd1};
    tbl[12] = '{1'b0,1'b1,4'hF,1'b0,1'b0,1'b0, 1'b0,1'b1,4'h0,1'b1,1'b1,1'b0,2'd2};
    tbl[13] = '{1'b0,1'b1,4'hF,1'b0,1'b1,1'b0, 1'b0,1'b1,4'h0,1'b1,1'b1,1'b0,2'd2};
    tbl[14] = '{1'b0,1'b0,4'h0,1'b0,1'b1,1'b0, 1'b1,1'b1,4'h6,1'b0,1'b0,1'b0,2'd1};
    tbl[15] = '{1'b0,1'b0,4'h0,1'b0,1'b1,1'b0, 1'b1,1'b0,4'h6,1'b0,1'b0,1'b0,2'd0};

    Reset         = 1'b1;
    bus.In_Valid  = 1'b0;
    bus.In_R      = 4'h0;
    bus.In_Op     = 1'b0;
    bus.Out_Ready = 1'b0;
    bus.Flush     = 1'b0;

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].rst, tbl[i].iv, tbl[i].r, tbl[i].op, tbl[i].ordy, tbl[i].fl);
      chk($sformatf("vec%0d", i), tbl[i].e_irdy, tbl[i].e_ov, tbl[i].e_r, tbl[i].e_op,
          tbl[i].e_z, tbl[i].e_n, tbl[i].e_cnt);
    end

    // Streaming push+pop for 20 beats. Values 0..15 repeat, Op = value LSB, and Count stays at 1.
    step(1'b0, 1'b1, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("stream0", 1'b1, 1'b0, 4'h6, 1'b0, 1'b0, 1'b0, 2'd0);
    for (int j = 1; j <= 20; j++) begin
      logic [3:0] pv, ev;
      pv = 4'(j % 16);
      ev = 4'((j - 1) % 16);
      step(1'b0, 1'b1, pv, pv[0], 1'b1, 1'b0);
      chk($sformatf("stream%0d", j), 1'b1, 1'b1, ev, ev[0], ev == 4'h0, ev[3], 2'd1);
    end
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("stream_drain", 1'b1, 1'b1, 4'h4, 1'b0, 1'b0, 1'b0, 2'd1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("stream_empty", 1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 2'd0);

    // Flush on a full buffer while In_Valid=1 and Out_Ready=1.
    step(1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
    chk("fl_a", 1'b1, 1'b0, 4'h4, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b0);
    chk("fl_b", 1'b1, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 2'd1);
    step(1'b0, 1'b1, 4'hC, 1'b0, 1'b1, 1'b1);
    chk("fl_full", 1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0, 2'd2);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("fl_after", 1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 2'd0);

    // Flush with one entry while In_Ready=1. The coincident beat must still be dropped.
    step(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    chk("fl1_push", 1'b1, 1'b0, 4'h5, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 4'hE, 1'b0, 1'b0, 1'b1);
    chk("fl1_flush", 1'b1, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 2'd1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("fl1_after", 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 4'h8, 1'b1, 1'b0, 1'b0);
    chk("fl1_repush", 1'b1, 1'b0, 4'h3, 1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("fl1_head", 1'b1, 1'b1, 4'h8, 1'b1, 1'b0, 1'b1, 2'd1);

    // A reset in the middle of traffic discards the entries and clears Out_R.
    step(1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    chk("rst_a", 1'b1, 1'b0, 4'h8, 1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
    chk("rst_b", 1'b1, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 2'd1);
    step(1'b1, 1'b1, 4'hF, 1'b0, 1'b1, 1'b1);
    chk("rst_hi", 1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0, 2'd2);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_after", 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0);

`ifdef LOGIC_BUF_PARITY_EN
    // Parity: ^0111 = 1 and ^0011 = 0. Out_P is gated by Out_Valid.
    step(1'b0, 1'b1, 4'h7, 1'b0, 1'b0, 1'b0);
    cmp("par_empty", "Out_P", 8'(bus.Out_P), 8'd0);
    step(1'b0, 1'b1, 4'h3, 1'b0, 1'b0, 1'b0);
    cmp("par_0111", "Out_P", 8'(bus.Out_P), 8'd1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    cmp("par_0111b", "Out_P", 8'(bus.Out_P), 8'd1);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    cmp("par_0011", "Out_P", 8'(bus.Out_P), 8'd0);
    cmp("par_0011", "Out_R", 8'(bus.Out_R), 8'h3);
    step(1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
    cmp("par_drained", "Out_P", 8'(bus.Out_P), 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
